// File: rtl/mux2_rr_arbiter_if.sv
// Handshake bundle between two data sources, the arbiter and one consumer.
// Ports: x1/x2 (+_valid/_ready) source side, s/f/f_valid/f_ready consumer side.
// Modports: master = arbiter (drives readies, s, f, f_valid); slave = surrounding env.
interface mux2_rr_arbiter_if #(
   parameter int DW = 1
);
   logic [DW-1:0] x1;
   logic          x1_valid;
   logic          x1_ready;
   logic [DW-1:0] x2;
   logic          x2_valid;
   logic          x2_ready;
   logic          s;
   logic [DW-1:0] f;
   logic          f_valid;
   logic          f_ready;

   modport master (
      input  x1, x1_valid, x2, x2_valid, f_ready,
      output x1_ready, x2_ready, s, f, f_valid
   );

   modport slave (
      output x1, x1_valid, x2, x2_valid, f_ready,
      input  x1_ready, x2_ready, s, f, f_valid
   );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin 2:1 arbiter with burst limit; registered select s and data f.
// Latency: 1 cycle source transfer -> f_valid; one bubble when leaving IDLE.
// Backpressure: readies drop while f is held (f_valid && !f_ready).
// Ports: clk, rst_n (async active-low), bus (mux2_rr_arbiter_if.master).
// Optional macro MUX2_ARB_STATS_EN adds saturating transfer counters cnt1/cnt2.
module mux2_rr_arbiter #(
   parameter int DW       = 1,
   parameter int MAXBURST = 4
) (
   input  logic clk,
   input  logic rst_n,
   mux2_rr_arbiter_if.master bus
`ifdef MUX2_ARB_STATS_EN
   ,
   output logic [15:0] cnt1,
   output logic [15:0] cnt2
`endif
);

   typedef enum logic [1:0] {IDLE, GNT1, GNT2} state_t;

   localparam logic [3:0] MAXB = 4'(MAXBURST);

   state_t        state;
   logic          last;      // most recently granted source: 0 = x1, 1 = x2
   logic [3:0]    burst;
   logic [3:0]    burst_inc;
   logic          s_q;
   logic [DW-1:0] f_q;
   logic          f_valid_q;
   logic          out_free;
   logic          t1;
   logic          t2;

   // A new word may enter f when f is empty or is being drained this cycle.
   assign out_free     = !f_valid_q || bus.f_ready;
   assign bus.x1_ready = (state == GNT1) && out_free;
   assign bus.x2_ready = (state == GNT2) && out_free;
   assign t1           = bus.x1_valid && bus.x1_ready;
   assign t2           = bus.x2_valid && bus.x2_ready;
   assign burst_inc    = burst + 4'd1;

   assign bus.s       = s_q;
   assign bus.f       = f_q;
   assign bus.f_valid = f_valid_q;

   // Grant FSM; s is registered alongside the state so they change together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         last  <= 1'b1;
         burst <= 4'd0;
         s_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               burst <= 4'd0;
               // On a tie, the source not granted last time wins.
               if (bus.x1_valid && (!bus.x2_valid || last)) begin
                  state <= GNT1;
                  last  <= 1'b0;
                  s_q   <= 1'b0;
               end else if (bus.x2_valid) begin
                  state <= GNT2;
                  last  <= 1'b1;
                  s_q   <= 1'b1;
               end
            end
            GNT1: begin
               if (!bus.x1_valid) begin
                  burst <= 4'd0;
                  if (bus.x2_valid) begin
                     state <= GNT2;
                     last  <= 1'b1;
                     s_q   <= 1'b1;
                  end else begin
                     state <= IDLE;
                     s_q   <= 1'b0;
                  end
               end else if (t1) begin
                  if (burst_inc == MAXB) begin
                     // Burst exhausted: hand over only if x2 is waiting.
                     burst <= 4'd0;
                     if (bus.x2_valid) begin
                        state <= GNT2;
                        last  <= 1'b1;
                        s_q   <= 1'b1;
                     end
                  end else begin
                     burst <= burst_inc;
                  end
               end
            end
            GNT2: begin
               if (!bus.x2_valid) begin
                  burst <= 4'd0;
                  if (bus.x1_valid) begin
                     state <= GNT1;
                     last  <= 1'b0;
                     s_q   <= 1'b0;
                  end else begin
                     state <= IDLE;
                     s_q   <= 1'b0;
                  end
               end else if (t2) begin
                  if (burst_inc == MAXB) begin
                     burst <= 4'd0;
                     if (bus.x1_valid) begin
                        state <= GNT1;
                        last  <= 1'b0;
                        s_q   <= 1'b0;
                     end
                  end else begin
                     burst <= burst_inc;
                  end
               end
            end
            default: begin
               state <= IDLE;
               burst <= 4'd0;
               s_q   <= 1'b0;
            end
         endcase
      end
   end

   // Output register: a simultaneous drain and load keeps f_valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q       <= '0;
         f_valid_q <= 1'b0;
      end else if (t1 || t2) begin
         f_q       <= t1 ? bus.x1 : bus.x2;
         f_valid_q <= 1'b1;
      end else if (bus.f_ready) begin
         f_valid_q <= 1'b0;
      end
   end

`ifdef MUX2_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt1 <= 16'd0;
         cnt2 <= 16'd0;
      end else begin
         if (t1 && (cnt1 != 16'hFFFF)) cnt1 <= cnt1 + 16'd1;
         if (t2 && (cnt2 != 16'hFFFF)) cnt2 <= cnt2 + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed stimulus with a scoreboard of expected output words.
module tb_mux2_rr_arbiter;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mux2_rr_arbiter_if #(.DW(DW)) bus ();

`ifdef MUX2_ARB_STATS_EN
   logic [15:0] cnt1;
   logic [15:0] cnt2;
`endif

   mux2_rr_arbiter #(.DW(DW), .MAXBURST(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef MUX2_ARB_STATS_EN
      ,
      .cnt1  (cnt1),
      .cnt2  (cnt2)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [DW-1:0] src1[$];
   logic [DW-1:0] src2[$];
   logic [DW-1:0] exp_q[$];
   int rd_idx = 0;
   bit en1 = 1'b0;
   bit en2 = 1'b0;
   bit f1;
   bit f2;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: every accepted output word is checked against the scoreboard.
   initial forever begin
      @(negedge clk);
      if (rst_n && bus.f_valid && bus.f_ready) begin
         if (rd_idx < exp_q.size()) begin
            chk("out_word", 32'(bus.f), 32'(exp_q[rd_idx]));
         end else begin
            n_tests++;
            n_fail++;
            $display("FAIL out_extra: got %0h expected no word", bus.f);
         end
         rd_idx++;
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive();
      bus.x1_valid = en1 && (src1.size() > 0);
      bus.x1       = (src1.size() > 0) ? src1[0] : '0;
      bus.x2_valid = en2 && (src2.size() > 0);
      bus.x2       = (src2.size() > 0) ? src2[0] : '0;
   endtask

   // One clock: record handshakes before the edge, advance sources after it.
   task automatic tick();
      @(negedge clk);
      f1 = bus.x1_valid && bus.x1_ready;
      f2 = bus.x2_valid && bus.x2_ready;
      @(posedge clk);
      #1;
      if (f1) void'(src1.pop_front());
      if (f2) void'(src2.pop_front());
      drive();
      #1;
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (rd_idx < exp_q.size() && k < budget) begin
         tick();
         k++;
      end
      chk("drain_words", 32'(rd_idx), 32'(exp_q.size()));
   endtask

   initial begin
      logic [7:0] ord_c[16];
      int sw;
      int lows;
      logic prev_s;

      bus.x1 = '0; bus.x2 = '0;
      bus.x1_valid = 1'b1; bus.x2_valid = 1'b1;
      bus.f_ready = 1'b1;

      // Reset holds everything idle even with both sources requesting.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s",        32'(bus.s), 0);
      chk("rst_f_valid",  32'(bus.f_valid), 0);
      chk("rst_f",        32'(bus.f), 0);
      chk("rst_x1_ready", 32'(bus.x1_ready), 0);
      chk("rst_x2_ready", 32'(bus.x2_ready), 0);
      drive();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single word from x1: one bubble, then latency of one cycle.
      src1.push_back(8'h01); exp_q.push_back(8'h01);
      en1 = 1'b1;
      drive();
      #1;
      chk("idle_x1_ready", 32'(bus.x1_ready), 0);
      tick();
      chk("bubble_f_valid", 32'(bus.f_valid), 0);
      chk("gnt1_x1_ready",  32'(bus.x1_ready), 1);
      chk("gnt1_s",         32'(bus.s), 0);
      tick();
      chk("lat1_f_valid", 32'(bus.f_valid), 1);
      chk("lat1_f",       32'(bus.f), 32'h01);
      drain(10);
      tick();
      chk("back_idle_x1_ready", 32'(bus.x1_ready), 0);

      // Both sources busy: bursts of 4 alternate, x2 first (x1 granted last).
      ord_c = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h10, 8'h11, 8'h12, 8'h13,
                8'h24, 8'h25, 8'h26, 8'h27, 8'h14, 8'h15, 8'h16, 8'h17};
      for (int i = 0; i < 8; i++) begin
         src1.push_back(8'h10 + 8'(i));
         src2.push_back(8'h20 + 8'(i));
      end
      for (int i = 0; i < 16; i++) exp_q.push_back(ord_c[i]);
      en1 = 1'b1; en2 = 1'b1;
      drive();
      sw = 0;
      prev_s = bus.s;
      for (int k = 0; k < 40 && rd_idx < exp_q.size(); k++) begin
         tick();
         if (bus.s !== prev_s) sw++;
         prev_s = bus.s;
      end
      chk("rr_s_toggles", 32'(sw), 4);
      drain(10);
      en2 = 1'b0;
      tick(); tick();

      // Consumer stall for 3 cycles in GNT1, then full throughput resumes.
      for (int i = 0; i < 6; i++) begin
         src1.push_back(8'h30 + 8'(i));
         exp_q.push_back(8'h30 + 8'(i));
      end
      drive();
      tick();
      tick();
      bus.f_ready = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_x1_ready", 32'(bus.x1_ready), 0);
         chk("stall_f",        32'(bus.f), 32'h30);
         chk("stall_f_valid",  32'(bus.f_valid), 1);
      end
      bus.f_ready = 1'b1;
      #1;
      repeat (5) tick();
      chk("resume_rate", 32'(src1.size()), 0);
      drain(10);
      en1 = 1'b0;
      tick();

      // Only x2 for 10 words: grant stays on x2 through counter wraps.
      for (int i = 0; i < 10; i++) begin
         src2.push_back(8'h40 + 8'(i));
         exp_q.push_back(8'h40 + 8'(i));
      end
      en2 = 1'b1;
      drive();
      tick();
      chk("solo_x2_s", 32'(bus.s), 1);
      lows = 0;
      repeat (10) begin
         tick();
         if (bus.s !== 1'b1) lows++;
      end
      chk("solo_x2_hold", 32'(lows), 0);
      chk("solo_x2_all",  32'(src2.size()), 0);
      drain(10);
      tick();

      // Reset mid-burst in GNT1: held word dropped, next tie goes to x1.
      for (int i = 0; i < 8; i++) begin
         src1.push_back(8'h50 + 8'(i));
         src2.push_back(8'h60 + 8'(i));
      end
      exp_q.push_back(8'h50);
      en1 = 1'b1; en2 = 1'b1;
      drive();
      tick();
      tick();
      tick();
      chk("pre_rst_f_valid", 32'(bus.f_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_f_valid",  32'(bus.f_valid), 0);
      chk("mid_rst_s",        32'(bus.s), 0);
      chk("mid_rst_x1_ready", 32'(bus.x1_ready), 0);
      chk("mid_rst_x2_ready", 32'(bus.x2_ready), 0);
      tick();
      chk("mid_rst_f", 32'(bus.f), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      ord_c = '{8'h52, 8'h53, 8'h54, 8'h55, 8'h60, 8'h61, 8'h62, 8'h63,
                8'h56, 8'h57, 8'h64, 8'h65, 8'h66, 8'h67, 8'h00, 8'h00};
      for (int i = 0; i < 14; i++) exp_q.push_back(ord_c[i]);
      tick();
      chk("post_rst_tie_s",  32'(bus.s), 0);
      chk("post_rst_x1_rdy", 32'(bus.x1_ready), 1);
      chk("post_rst_x2_rdy", 32'(bus.x2_ready), 0);
      drain(40);
      tick();

`ifdef MUX2_ARB_STATS_EN
      // Saturation of the transfer counters.
      en2 = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("stats_rst_cnt1", 32'(cnt1), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 70000; i++) begin
         src1.push_back(8'(i));
         exp_q.push_back(8'(i));
      end
      en1 = 1'b1;
      drive();
      drain(70100);
      tick();
      chk("stats_cnt1", 32'(cnt1), 32'hFFFF);
      chk("stats_cnt2", 32'(cnt2), 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mux2_rr_arbiter.md
MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 1, giving the data width of each source and of the output.
REQ-002 The block SHALL have parameter MAXBURST, default 4 (legal range 1..15), giving the maximum consecutive transfers from one source while the other source is waiting.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port x1, input, DW bits: source 1 data.
REQ-006 The block SHALL have port x1_valid, input, 1 bit: source 1 data present.
REQ-007 The block SHALL have port x1_ready, output, 1 bit: source 1 transfer accepted this cycle.
REQ-008 The block SHALL have ports x2, x2_valid and x2_ready with the same widths and meanings for source 2.
REQ-009 The block SHALL have port s, output, 1 bit: registered select for the downstream 2:1 mux (0 = x1, 1 = x2).
REQ-010 The block SHALL have port f, output, DW bits: registered selected data.
REQ-011 The block SHALL have port f_valid, output, 1 bit: f holds data.
REQ-012 The block SHALL have port f_ready, input, 1 bit: consumer accepts f this cycle.

Function
REQ-013 A transfer on source i SHALL occur when xi_valid and xi_ready are both 1 on a rising edge; an output transfer SHALL occur when f_valid and f_ready are both 1.
REQ-014 The FSM SHALL have exactly the states IDLE, GNT1 and GNT2; s SHALL be 1 only in GNT2.
REQ-015 xi_ready SHALL be (state == GNTi) AND (!f_valid OR f_ready); at most one ready SHALL be 1 in any cycle.
REQ-016 On a source-i transfer, f SHALL load xi and f_valid SHALL be 1 on the next cycle (latency 1 cycle); full throughput of one word per cycle SHALL be sustained.
REQ-017 With f_valid=1, f_ready=0 and no source transfer, f and f_valid SHALL hold unchanged.
REQ-018 On an output transfer with no source transfer in the same cycle, f_valid SHALL clear; a simultaneous output transfer and source transfer SHALL keep f_valid=1 with the new data.
REQ-019 From IDLE, the next state SHALL be GNT1 if only x1_valid is set, GNT2 if only x2_valid is set, and otherwise stay IDLE.
REQ-020 From IDLE with both valids set, the next state SHALL be the source not recorded in register last (round robin); last SHALL update to i on each entry to GNTi.
REQ-021 Leaving IDLE SHALL cost exactly one bubble cycle: no source transfer occurs in the cycle the grant is decided.
REQ-022 In GNTi, a 4-bit burst counter SHALL increment on each source-i transfer; it SHALL clear on every state change.
REQ-023 In GNTi with xi_valid=0, the next state SHALL be GNTother if the other valid is set, else IDLE.
REQ-024 In GNTi, when the transfer that makes the counter reach MAXBURST occurs, the next state SHALL be GNTother if the other valid is set; otherwise the counter SHALL clear and the state SHALL stay GNTi.
REQ-025 A grant switch SHALL never drop or duplicate a word; s SHALL change in the same edge as the state.

Reset
REQ-026 While rst_n=0, the block SHALL hold state=IDLE, last=2, counter=0, s=0, f=0 and f_valid=0, regardless of clk.
REQ-027 Reset asserted mid-operation SHALL discard any held word; both readies SHALL be 0 until the first edge after deassertion.
REQ-028 Deassertion of rst_n SHALL be used as is; any synchronization is the integrator's responsibility.

Configuration
REQ-029 With macro MUX2_ARB_STATS_EN defined, the block SHALL add outputs cnt1[15:0] and cnt2[15:0], counting source-1 and source-2 transfers, saturating at 16'hFFFF, and cleared by reset.
REQ-030 Without MUX2_ARB_STATS_EN, these ports and counters SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then x1_valid=1 with x1=1 and f_ready=1: GNT1 after 1 bubble cycle, s=0, f=1 with f_valid=1 one cycle after the transfer.
REQ-032 Both valids held and f_ready=1 with MAXBURST=4: output order SHALL be 4 words from x1, then 4 from x2, repeating; s SHALL toggle on every 4th transfer.
REQ-033 In GNT1 with f_valid=1, f_ready=0 for 3 cycles: x1_ready=0 and f held for 3 cycles; then f_ready=1 SHALL resume throughput of 1 word per cycle.
REQ-034 Only x2 valid for 10 words: 10 consecutive x2 transfers, state stays GNT2, counter wraps at 4 without a switch.
REQ-035 rst_n pulsed low while f_valid=1 mid-burst: f_valid=0, s=0 and state IDLE immediately; the next tie SHALL be granted to x1.
REQ-036 With MUX2_ARB_STATS_EN, 70000 x1 transfers SHALL give cnt1=16'hFFFF and cnt2=0.
